// File: rtl/gate_bus_arbiter.sv
// Round-robin arbiter that time-shares one gated register between several requesters,
// sequencing CTRL/CE for a fixed hold window, acknowledging, and optionally flushing.
module gate_bus_arbiter #(
   parameter int C_WIDTH         = 16,
   parameter int C_NUM_REQ       = 4,
   parameter int C_HOLD_CYCLES   = 2,
   parameter int C_CLEAR_BETWEEN = 1
) (
   input  logic                         CLK,
   input  logic                         ACLR_N,
   input  logic [C_NUM_REQ-1:0]         REQ,
   input  logic [C_NUM_REQ*C_WIDTH-1:0] DATA,
   output logic [C_NUM_REQ-1:0]         GNT,
   output logic [C_NUM_REQ-1:0]         ACK,
   output logic [C_WIDTH-1:0]           GATE_I,
   output logic                         GATE_CTRL,
   output logic                         GATE_CE,
   output logic                         GATE_SCLR,
   output logic                         Q_VALID,
   output logic [2:0]                   Q_SRC,
   output logic                         BUSY,
   output logic [1:0]                   DBG_STATE
);

   // Handshake: a requester raises REQ[k] and holds REQ/DATA stable until it sees
   // a one-cycle ACK[k]; dropping REQ[k] while granted aborts the grant without ACK.
   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_GATE  = 2'd1,
      S_CLEAR = 2'd2
   } state_t;

   localparam state_t C_EXIT = (C_CLEAR_BETWEEN != 0) ? S_CLEAR : S_IDLE;

   state_t               r_state;
   state_t               w_next;
   logic [2:0]           r_last;
   logic [2:0]           r_idx;
   logic [2:0]           r_q_src;
   logic [3:0]           r_cnt;
   logic [C_NUM_REQ-1:0] r_gnt;
   logic [C_NUM_REQ-1:0] r_ack;
   logic                 r_q_valid;

   logic [2:0]           w_winner;
   logic                 w_found;
   logic [C_NUM_REQ-1:0] w_win_oh;
   logic [C_NUM_REQ-1:0] w_idx_oh;
   logic                 w_req_sel;
   logic [C_WIDTH-1:0]   w_data_sel;
   logic                 w_done;
   logic                 w_abort;
   logic                 w_ce;

   // Search starts just after the previous winner and wraps around.
   always_comb begin
      w_found  = 1'b0;
      w_winner = '0;
      for (int off = 1; off <= C_NUM_REQ; off++) begin
         for (int k = 0; k < C_NUM_REQ; k++) begin
            if (!w_found && REQ[k] && (((int'(r_last) + off) % C_NUM_REQ) == k)) begin
               w_found  = 1'b1;
               w_winner = 3'(k);
            end
         end
      end
   end

   always_comb begin
      w_win_oh   = '0;
      w_idx_oh   = '0;
      w_req_sel  = 1'b0;
      w_data_sel = '0;
      for (int k = 0; k < C_NUM_REQ; k++) begin
         if (w_winner == 3'(k)) begin
            w_win_oh[k] = 1'b1;
         end
         if (r_idx == 3'(k)) begin
            w_idx_oh[k] = 1'b1;
            w_req_sel   = REQ[k];
            w_data_sel  = DATA[k*C_WIDTH +: C_WIDTH];
         end
      end
   end

   always_comb begin
      w_next  = r_state;
      w_done  = 1'b0;
      w_abort = 1'b0;
      case (r_state)
         S_IDLE: begin
            if (w_found) begin
               w_next = S_GATE;
            end
         end
         S_GATE: begin
            // An abort takes priority over completing the final hold cycle.
            if (!w_req_sel) begin
               w_abort = 1'b1;
               w_next  = C_EXIT;
            end else if (r_cnt == 4'(C_HOLD_CYCLES - 1)) begin
               w_done = 1'b1;
               w_next = C_EXIT;
            end
         end
         S_CLEAR: begin
            w_next = S_IDLE;
         end
         default: begin
            w_next = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge CLK or negedge ACLR_N) begin
      if (!ACLR_N) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_next;
      end
   end

   always_ff @(posedge CLK or negedge ACLR_N) begin
      if (!ACLR_N) begin
         r_last    <= 3'(C_NUM_REQ - 1);
         r_idx     <= '0;
         r_cnt     <= '0;
         r_gnt     <= '0;
         r_ack     <= '0;
         r_q_valid <= 1'b0;
         r_q_src   <= '0;
      end else begin
         r_ack     <= '0;
         r_q_valid <= (r_state == S_GATE) && w_ce;
         if ((r_state == S_GATE) && w_ce) begin
            r_q_src <= r_idx;
         end
         case (r_state)
            S_IDLE: begin
               if (w_found) begin
                  r_last <= w_winner;
                  r_idx  <= w_winner;
                  r_gnt  <= w_win_oh;
                  r_cnt  <= '0;
               end
            end
            S_GATE: begin
               r_cnt <= r_cnt + 4'd1;
               if (w_done) begin
                  r_ack <= w_idx_oh;
               end
               if (w_done || w_abort) begin
                  r_gnt <= '0;
               end
            end
            default: begin
               r_gnt <= '0;
            end
         endcase
      end
   end

   // CE is suppressed during an aborting GATE cycle so the register keeps its value.
   assign w_ce      = ((r_state == S_GATE) && w_req_sel) || (r_state == S_CLEAR);
   assign GATE_CE   = w_ce;
   assign GATE_CTRL = (r_state == S_GATE);
   assign GATE_SCLR = (r_state == S_CLEAR);
   assign GATE_I    = (r_state == S_GATE) ? w_data_sel : '0;
   assign GNT       = r_gnt;
   assign ACK       = r_ack;
   assign Q_VALID   = r_q_valid;
   assign Q_SRC     = r_q_src;
   assign BUSY      = (r_state != S_IDLE);
   assign DBG_STATE = r_state;

endmodule

// File: tb/tb_gate_bus_arbiter.sv
// Directed bench for gate_bus_arbiter: one instance with the flush cycle, one without.
module tb_gate_bus_arbiter;

   logic        clk;
   logic        rst_n;

   logic [3:0]  req1;
   logic [63:0] data1;
   logic [3:0]  gnt1, ack1;
   logic [15:0] gate_i1;
   logic        ctrl1, ce1, sclr1, qv1, busy1;
   logic [2:0]  qsrc1;
   logic [1:0]  dbg1;

   logic [3:0]  req0;
   logic [63:0] data0;
   logic [3:0]  gnt0, ack0;
   logic [15:0] gate_i0;
   logic        ctrl0, ce0, sclr0, qv0, busy0;
   logic [2:0]  qsrc0;
   logic [1:0]  dbg0;

   int n_chk  = 0;
   int n_pass = 0;

   logic [15:0] tbl [4] = '{16'h1357, 16'h2468, 16'hBEEF, 16'hCAFE};

   gate_bus_arbiter #(.C_WIDTH(16), .C_NUM_REQ(4), .C_HOLD_CYCLES(2), .C_CLEAR_BETWEEN(1)) u_clr (
      .CLK(clk), .ACLR_N(rst_n), .REQ(req1), .DATA(data1), .GNT(gnt1), .ACK(ack1),
      .GATE_I(gate_i1), .GATE_CTRL(ctrl1), .GATE_CE(ce1), .GATE_SCLR(sclr1),
      .Q_VALID(qv1), .Q_SRC(qsrc1), .BUSY(busy1), .DBG_STATE(dbg1)
   );

   gate_bus_arbiter #(.C_WIDTH(16), .C_NUM_REQ(4), .C_HOLD_CYCLES(2), .C_CLEAR_BETWEEN(0)) u_noclr (
      .CLK(clk), .ACLR_N(rst_n), .REQ(req0), .DATA(data0), .GNT(gnt0), .ACK(ack0),
      .GATE_I(gate_i0), .GATE_CTRL(ctrl0), .GATE_CE(ce0), .GATE_SCLR(sclr0),
      .Q_VALID(qv0), .Q_SRC(qsrc0), .BUSY(busy0), .DBG_STATE(dbg0)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s: got %0h expected %0h", tag, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [3:0] oh(input int k);
      logic [3:0] v;
      v = 4'b0001 << k;
      return v;
   endfunction

   // Expects REQ already set so that requester k wins at the next edge.
   task automatic run_grant(input int k, input logic [15:0] d);
      step();
      check("gnt", 32'(gnt1), 32'(oh(k)));
      check("gate_i", 32'(gate_i1), 32'(d));
      check("ctrl", 32'(ctrl1), 32'd1);
      check("ce", 32'(ce1), 32'd1);
      check("busy", 32'(busy1), 32'd1);
      step();
      check("hold_ce", 32'(ce1), 32'd1);
      check("q_valid", 32'(qv1), 32'd1);
      check("q_src", 32'(qsrc1), 32'(k));
      check("ack_early", 32'(ack1), 32'd0);
      step();
      check("ack", 32'(ack1), 32'(oh(k)));
      check("gnt_drop", 32'(gnt1), 32'd0);
      check("sclr", 32'(sclr1), 32'd1);
      check("ce_clr", 32'(ce1), 32'd1);
      check("ctrl_clr", 32'(ctrl1), 32'd0);
      check("gate_i_clr", 32'(gate_i1), 32'd0);
      check("qv_clr", 32'(qv1), 32'd1);
      step();
      check("busy_idle", 32'(busy1), 32'd0);
      check("ack_end", 32'(ack1), 32'd0);
      check("qv_end", 32'(qv1), 32'd0);
      check("sclr_end", 32'(sclr1), 32'd0);
   endtask

   task automatic do_reset();
      rst_n = 1'b0;
      step();
      step();
      check("rst_gnt", 32'(gnt1), 32'd0);
      check("rst_busy", 32'(busy1), 32'd0);
      check("rst_ce", 32'(ce1), 32'd0);
      check("rst_qv", 32'(qv1), 32'd0);
      rst_n = 1'b1;
   endtask

   initial begin
      rst_n = 1'b0;
      req1  = '0;
      data1 = '0;
      req0  = '0;
      data0 = '0;
      #2;
      check("por_gnt", 32'(gnt1), 32'd0);
      check("por_ack", 32'(ack1), 32'd0);
      check("por_gate_i", 32'(gate_i1), 32'd0);
      check("por_sclr", 32'(sclr1), 32'd0);
      check("por_dbg", 32'(dbg1), 32'd0);
      check("por0_gnt", 32'(gnt0), 32'd0);
      check("por0_busy", 32'(busy0), 32'd0);
      step();
      rst_n = 1'b1;
      step();

      // Single request, requester 0.
      data1[15:0] = 16'hA5A5;
      req1 = 4'b0001;
      #1;
      check("pre_gnt", 32'(gnt1), 32'd0);
      check("pre_busy", 32'(busy1), 32'd0);
      run_grant(0, 16'hA5A5);
      req1 = 4'b0000;

      // Rotation from reset: all four requesting.
      do_reset();
      for (int k = 0; k < 4; k++) data1[k*16 +: 16] = tbl[k];
      req1 = 4'b1111;
      for (int k = 0; k < 4; k++) begin
         run_grant(k, tbl[k]);
         req1[k] = 1'b0;
      end

      // After a grant to 2, requester 0 is next, then 2 again.
      req1 = 4'b0100;
      run_grant(2, tbl[2]);
      req1 = 4'b0101;
      run_grant(0, tbl[0]);
      run_grant(2, tbl[2]);
      req1 = 4'b0000;

      // Abort in the first GATE cycle.
      req1 = 4'b0010;
      step();
      check("ab_gnt", 32'(gnt1), 32'b0010);
      req1 = 4'b0000;
      #1;
      check("ab_ce", 32'(ce1), 32'd0);
      check("ab_ctrl", 32'(ctrl1), 32'd1);
      step();
      check("ab_sclr", 32'(sclr1), 32'd1);
      check("ab_ack", 32'(ack1), 32'd0);
      check("ab_gnt_drop", 32'(gnt1), 32'd0);
      check("ab_qv", 32'(qv1), 32'd0);
      step();
      check("ab_busy", 32'(busy1), 32'd0);
      check("ab_ack2", 32'(ack1), 32'd0);
      check("ab_sclr2", 32'(sclr1), 32'd0);

      // Asynchronous reset in the middle of a grant.
      req1 = 4'b0001;
      step();
      check("mr_gnt", 32'(gnt1), 32'b0001);
      step();
      check("mr_qv", 32'(qv1), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      check("ar_gnt", 32'(gnt1), 32'd0);
      check("ar_ack", 32'(ack1), 32'd0);
      check("ar_ce", 32'(ce1), 32'd0);
      check("ar_ctrl", 32'(ctrl1), 32'd0);
      check("ar_sclr", 32'(sclr1), 32'd0);
      check("ar_gate_i", 32'(gate_i1), 32'd0);
      check("ar_qv", 32'(qv1), 32'd0);
      check("ar_busy", 32'(busy1), 32'd0);
      req1 = 4'b1000;
      #1;
      rst_n = 1'b1;
      run_grant(3, tbl[3]);
      req1 = 4'b0000;

      // No flush cycle: two requesters alternate every 3 cycles.
      data0[15:0]  = 16'h0F0F;
      data0[31:16] = 16'hF0F0;
      req0 = 4'b0011;
      for (int i = 0; i < 4; i++) begin
         step();
         check("nc_gnt", 32'(gnt0), 32'(oh(i % 2)));
         check("nc_gate_i", 32'(gate_i0), (i % 2 == 0) ? 32'h0F0F : 32'hF0F0);
         check("nc_sclr_a", 32'(sclr0), 32'd0);
         step();
         check("nc_sclr_b", 32'(sclr0), 32'd0);
         check("nc_ce", 32'(ce0), 32'd1);
         step();
         check("nc_ack", 32'(ack0), 32'(oh(i % 2)));
         check("nc_gnt_drop", 32'(gnt0), 32'd0);
         check("nc_sclr_c", 32'(sclr0), 32'd0);
         check("nc_busy", 32'(busy0), 32'd0);
         check("nc_qv", 32'(qv0), 32'd1);
         check("nc_qsrc", 32'(qsrc0), 32'(i % 2));
      end
      req0 = 4'b0000;
      step();
      check("nc_end_busy", 32'(busy0), 32'd0);
      check("nc_end_qv", 32'(qv0), 32'd0);

      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
